// File: rtl/game_round_ctrl_pkg.sv
// Shared constants for the game round controller: state codes, LFSR taps, defaults.
// Latency: n/a (constants and a pure combinational helper only).
// Backpressure: n/a.
package game_round_ctrl_pkg;

    // 500000 cycles is 10 ms at 50 MHz. 5001 cycles covers one 0.1 ms timer tick.
    localparam int DEB_CYCLES_DEF = 500000;
    localparam int MISS_HOLD_DEF  = 5001;

    // Fibonacci taps 8,6,5,4 expressed as bit positions 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // Round state encoding.
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_LOAD    = 3'd1;
    localparam logic [2:0] ST_PLAY    = 3'd2;
    localparam logic [2:0] ST_PENALTY = 3'd3;
    localparam logic [2:0] ST_FAIL    = 3'd4;
    localparam logic [2:0] ST_WIN     = 3'd5;

    // One LFSR step: shift left and feed the tap parity into bit 0.
    function automatic logic [7:0] lfsr_step(input logic [7:0] cur);
        return {cur[6:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/game_round_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-count debouncer, rising-edge press pulse.
// Latency: raw change to debounced level = 2 + DEB_CYCLES cycles; press pulse follows the level flip.
// Backpressure: none; press is a single-cycle pulse that is never held or queued.
// Ports: clock, reset (async active-low), btn_raw (asynchronous button), press (1-cycle pulse).
module btn_debounce
    import game_round_ctrl_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          level_q, level_d;
    logic          level_prev_q, level_prev_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d      = btn_raw;
        sync2_d      = sync1_q;
        level_prev_d = level_q;
        level_d      = level_q;
        cnt_d        = '0;
        // Any sample that agrees with the current level restarts the count.
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) begin
                level_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            level_q      <= 1'b0;
            level_prev_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            cnt_q        <= cnt_d;
        end
    end

    assign press = level_q & ~level_prev_q;

endmodule

// File: rtl/game_round_ctrl.sv
// Game round controller: shows a random one-hot target, judges player presses, drives timer start/miss.
// Latency: press pulse to score/miss update 1 cycle; raw button to press pulse 2 + DEB_CYCLES + 1 cycles.
// Backpressure: none; presses during LOAD/PENALTY/IDLE/FAIL/WIN are dropped, game_fail wins over presses.
// Ports: clock, reset (async active-low), btn_start, btn[3:0], game_fail in;
//        start, miss, target[3:0], score[7:0], win, lose out.
module game_round_ctrl
    import game_round_ctrl_pkg::*;
#(
    parameter int         DEB_CYCLES = DEB_CYCLES_DEF,
    parameter int         MISS_HOLD  = MISS_HOLD_DEF,
    parameter int         SCORE_MAX  = 99,
    parameter logic [7:0] LFSR_SEED  = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       btn_start,
    input  logic [3:0] btn,
    input  logic       game_fail,
    output logic       start,
    output logic       miss,
    output logic [3:0] target,
    output logic [7:0] score,
    output logic       win,
    output logic       lose
);

    localparam int HW = $clog2(MISS_HOLD + 1);

    logic          start_press;
    logic [3:0]    btn_press;

    logic [2:0]    state_q, state_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic [3:0]    target_q, target_d;
    logic [7:0]    score_q, score_d;
    logic [HW-1:0] hold_q, hold_d;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clock   (clock),
        .reset   (reset),
        .btn_raw (btn_start),
        .press   (start_press)
    );

    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
        btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clock   (clock),
            .reset   (reset),
            .btn_raw (btn[gi]),
            .press   (btn_press[gi])
        );
    end

    always_comb begin
        state_d  = state_q;
        score_d  = score_q;
        target_d = target_q;
        hold_d   = hold_q;
        lfsr_d   = lfsr_step(lfsr_q);
        case (state_q)
            ST_IDLE: begin
                if (start_press) begin
                    state_d = ST_LOAD;
                    score_d = '0;
                end
            end
            ST_LOAD: begin
                target_d = 4'b0001 << lfsr_q[1:0];
                state_d  = ST_PLAY;
            end
            ST_PLAY: begin
                if (game_fail) begin
                    state_d  = ST_FAIL;
                    target_d = '0;
                end else if (|btn_press) begin
                    // Multi-button vectors never equal a one-hot target, so they land in PENALTY.
                    if (btn_press == target_q) begin
                        score_d = score_q + 8'd1;
                        if (score_q == 8'(SCORE_MAX - 1)) begin
                            state_d  = ST_WIN;
                            target_d = '0;
                        end else begin
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_PENALTY;
                        hold_d  = '0;
                    end
                end
            end
            ST_PENALTY: begin
                if (game_fail) begin
                    state_d  = ST_FAIL;
                    target_d = '0;
                end else if (hold_q == HW'(MISS_HOLD - 1)) begin
                    state_d = ST_LOAD;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_FAIL, ST_WIN: begin
                // Score is cleared on the way back so the idle display reads zero.
                if (start_press) begin
                    state_d = ST_IDLE;
                    score_d = '0;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                target_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            lfsr_q   <= LFSR_SEED;
            target_q <= '0;
            score_q  <= '0;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            lfsr_q   <= lfsr_d;
            target_q <= target_d;
            score_q  <= score_d;
            hold_q   <= hold_d;
        end
    end

    // Decoded straight from state flops, so reset clears them without waiting for a clock.
    assign start  = (state_q == ST_PLAY) || (state_q == ST_PENALTY);
    assign miss   = (state_q == ST_PENALTY);
    assign win    = (state_q == ST_WIN);
    assign lose   = (state_q == ST_FAIL);
    assign target = target_q;
    assign score  = score_q;

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl against an action-level reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_game_round_ctrl;

    localparam int         DEB  = 4;
    localparam int         HOLD = 8;
    localparam int         SMAX = 3;
    localparam logic [7:0] SEED = 8'hA5;

    logic       clock     = 1'b0;
    logic       reset     = 1'b0;
    logic       btn_start = 1'b0;
    logic [3:0] btn       = 4'b0;
    logic       game_fail = 1'b0;
    logic       start, miss, win, lose;
    logic [3:0] target;
    logic [7:0] score;

    game_round_ctrl #(
        .DEB_CYCLES (DEB),
        .MISS_HOLD  (HOLD),
        .SCORE_MAX  (SMAX),
        .LFSR_SEED  (SEED)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .btn_start (btn_start),
        .btn       (btn),
        .game_fail (game_fail),
        .start     (start),
        .miss      (miss),
        .target    (target),
        .score     (score),
        .win       (win),
        .lose      (lose)
    );

    always #5 clock = ~clock;

    // Posedge counter; rel marks its value at reset release so the LFSR age is cyc - rel.
    int unsigned cyc = 0;
    int unsigned rel = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: game phase, score, displayed target.
    localparam int M_IDLE = 0, M_PLAY = 1, M_FAIL = 2, M_WIN = 3;
    int         m_st    = M_IDLE;
    int         m_score = 0;
    logic [3:0] m_tgt   = 4'b0;

    // Raw press drives at a negedge; pulse reaches the FSM at posedge 7, so the
    // round update is seen at negedge 7 and a LOAD entered there shows its target at negedge 8.
    localparam int K_HIT = 2 + DEB + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Target shown after a LOAD entered n posedges after reset release.
    function automatic logic [3:0] tgt_at(input int unsigned n);
        logic [7:0] s;
        logic [3:0] one;
        s   = SEED;
        one = 4'b0001;
        for (int unsigned i = 0; i < n; i++) s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        return one << s[1:0];
    endfunction

    function automatic logic [3:0] wrong_vec();
        logic [3:0] v;
        do v = 4'($urandom_range(1, 15)); while (v == m_tgt);
        return v;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, " start"},  start,  m_st == M_PLAY);
        chk({tag, " miss"},   miss,   1'b0);
        chk({tag, " win"},    win,    m_st == M_WIN);
        chk({tag, " lose"},   lose,   m_st == M_FAIL);
        chk({tag, " score"},  score,  m_score);
        chk({tag, " target"}, target, (m_st == M_PLAY) ? m_tgt : 4'b0);
    endtask

    // One raw press (start button or player vector) held 10 cycles, optionally with
    // game_fail raised for 2 cycles at negedge fail_at (0 = none).
    task automatic press(input bit is_start, input logic [3:0] vec, input int fail_at, input string tag);
        int unsigned n0;
        int          nxt, new_score, load_edge, fail_edge, exp_miss, miss_seen;
        logic [3:0]  extra;
        n0 = cyc - rel;
        nxt = m_st; new_score = m_score; load_edge = 0; fail_edge = 0;
        exp_miss = 0; miss_seen = 0; extra = 4'b0;
        if (m_st == M_PLAY && fail_at inside {[1:6]}) begin
            nxt = M_FAIL; fail_edge = fail_at + 1;
        end else if (is_start) begin
            if (m_st == M_IDLE) begin
                nxt = M_PLAY; new_score = 0; load_edge = K_HIT;
            end else if (m_st != M_PLAY) begin
                nxt = M_IDLE; new_score = 0;
            end
        end else if (m_st == M_PLAY && vec != 4'b0) begin
            if (vec == m_tgt) begin
                new_score = m_score + 1;
                if (new_score == SMAX) nxt = M_WIN;
                else load_edge = K_HIT;
            end else begin
                extra = m_tgt;   // target pressed mid-penalty must be ignored
                if (fail_at inside {[K_HIT:K_HIT + HOLD - 1]}) begin
                    nxt = M_FAIL; exp_miss = fail_at - (K_HIT - 1); fail_edge = fail_at + 1;
                end else begin
                    exp_miss = HOLD; load_edge = K_HIT + HOLD;
                end
            end
        end
        btn_start = is_start;
        btn       = is_start ? 4'b0 : vec;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            if (miss) miss_seen++;
            if (k == K_HIT - 1) chk({tag, " score_before"}, score, m_score);
            if (k == K_HIT) begin
                chk({tag, " score_upd"}, score, new_score);
                chk({tag, " miss_upd"},  miss,  exp_miss > 0);
            end
            if (load_edge != 0 && k == load_edge + 1) begin
                chk({tag, " start_play"}, start,  1'b1);
                chk({tag, " new_target"}, target, tgt_at(n0 + load_edge));
            end
            if (fail_edge != 0 && k == fail_edge) begin
                chk({tag, " lose_next"}, lose, 1'b1);
                chk({tag, " miss_drop"}, miss, 1'b0);
            end
            if (k == fail_at)     game_fail = 1'b1;
            if (k == fail_at + 2) game_fail = 1'b0;
            if (k == 2)           btn = btn | extra;
            if (k == 10) begin
                btn = 4'b0; btn_start = 1'b0;
            end
        end
        chk({tag, " miss_len"}, miss_seen, exp_miss);
        m_st = nxt; m_score = new_score;
        if (load_edge != 0) m_tgt = tgt_at(n0 + load_edge);
        else if (nxt != M_PLAY) m_tgt = 4'b0;
        check_model(tag);
    endtask

    // A raw pulse shorter than the debounce window must change nothing.
    task automatic glitch(input bit on_start, input int bitn);
        if (on_start) btn_start = 1'b1;
        else btn[bitn] = 1'b1;
        repeat (DEB - 1) @(negedge clock);
        btn_start = 1'b0; btn = 4'b0;
        repeat (12) @(negedge clock);
        check_model("glitch");
    endtask

    task automatic fail_pulse();
        game_fail = 1'b1;
        repeat (2) @(negedge clock);
        game_fail = 1'b0;
        @(negedge clock);
        if (m_st == M_PLAY) begin
            m_st = M_FAIL; m_tgt = 4'b0;
        end
        check_model("gfail");
    endtask

    // Reset asserted between edges; outputs must clear before the next posedge.
    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("areset start",  start,  1'b0);
        chk("areset miss",   miss,   1'b0);
        chk("areset win",    win,    1'b0);
        chk("areset lose",   lose,   1'b0);
        chk("areset score",  score,  8'd0);
        chk("areset target", target, 4'b0);
        m_st = M_IDLE; m_score = 0; m_tgt = 4'b0;
        btn = 4'b0; btn_start = 1'b0; game_fail = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1; rel = cyc;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_model("reset");
        reset = 1'b1; rel = cyc;
        repeat (2) @(negedge clock);

        press(1'b1, 4'b0, 0, "start");
        press(1'b0, m_tgt, 0, "hit");
        press(1'b0, wrong_vec(), 0, "wrong");
        glitch(1'b0, 2);
        glitch(1'b1, 0);
        press(1'b0, wrong_vec(), K_HIT + 3, "pen_fail");
        press(1'b1, 4'b0, 0, "fail_to_idle");
        press(1'b1, 4'b0, 0, "start2");
        for (int i = 0; i < SMAX; i++) press(1'b0, m_tgt, 0, "to_win");
        press(1'b1, 4'b0, 0, "win_to_idle");
        press(1'b1, 4'b0, 0, "start3");
        press(1'b0, m_tgt, K_HIT - 1, "fail_prio");
        press(1'b1, 4'b0, 0, "idle4");
        press(1'b1, 4'b0, 0, "start4");
        do_reset();
        check_model("post_reset");

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (m_st != M_PLAY) begin
                if (r < 60)      press(1'b1, 4'b0, 0, "r_start");
                else if (r < 75) press(1'b0, 4'($urandom_range(1, 15)), 0, "r_idle_btn");
                else if (r < 88) glitch(1'($urandom_range(0, 1)), $urandom_range(0, 3));
                else             fail_pulse();
            end else begin
                if (r < 45)      press(1'b0, m_tgt, 0, "r_hit");
                else if (r < 63) press(1'b0, wrong_vec(), 0, "r_miss");
                else if (r < 70) press(1'b0, wrong_vec(), $urandom_range(K_HIT, K_HIT + HOLD - 1), "r_pen_fail");
                else if (r < 76) press(1'b0, 4'($urandom_range(1, 15)), $urandom_range(1, K_HIT - 1), "r_fail");
                else if (r < 84) press(1'b1, 4'b0, 0, "r_start_play");
                else if (r < 93) glitch(1'($urandom_range(0, 1)), $urandom_range(0, 3));
                else             fail_pulse();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, n_cmp %0d", n_cmp);
        $fatal(1);
    end

endmodule
